// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control-bit positions, MEM-stage FSM
// encoding and the MEM/WB register payload.
package mips_pkg;

  localparam int unsigned RW_BIT  = 1;
  localparam int unsigned M2R_BIT = 0;

  localparam int unsigned BR_BIT  = 2;
  localparam int unsigned MR_BIT  = 1;
  localparam int unsigned MW_BIT  = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        valid;
  } memwb_t;

endpackage

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register with asynchronous active-low reset and load enable.
module memwb_reg
  import mips_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   load_i,
  input  memwb_t d_i,
  output memwb_t q_o
);

  memwb_t memwb_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      memwb_q <= '0;
    end else if (load_i) begin
      memwb_q <= d_i;
    end
  end

  assign q_o = memwb_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: branch resolve, req/ready data-memory handshake with timeout,
// upstream stall generation and MEM/WB register update.
module mem_stage_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Valid_IN,
  input  logic [1:0]  WB_IN,
  input  logic [2:0]  MEM_IN,
  input  logic [31:0] BranchPC_IN,
  input  logic        Zero_IN,
  input  logic [31:0] AluResult_IN,
  input  logic [31:0] RD2_IN,
  input  logic [4:0]  WR_IN,
  output logic        Stall,
  output logic        PCSrc,
  output logic [31:0] BranchPC_OUT,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [31:0] DMemWData,
  input  logic [31:0] DMemRData,
  input  logic        DMemReady,
  output logic [1:0]  WB_OUT,
  output logic [31:0] ReadData_OUT,
  output logic [31:0] AluResult_OUT,
  output logic [4:0]  WR_OUT,
  output logic        Valid_OUT,
  output logic        MemErr
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic             stall_c;
  logic             load_c;
  logic             memop;
  logic             at_last;
  memwb_t           memwb_d, memwb_q;

  assign memop   = Valid_IN & (MEM_IN[MR_BIT] | MEM_IN[MW_BIT]);
  assign at_last = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    err_d   = err_q;
    stall_c = 1'b0;
    load_c  = 1'b1;
    memwb_d = '{wb: WB_IN, rdata: '0, alu: AluResult_IN, wr: WR_IN, valid: Valid_IN};
    unique case (state_q)
      IDLE: begin
        if (memop) begin
          if (MEM_IN[MR_BIT] && MEM_IN[MW_BIT]) err_d = 1'b1;
          if (AluResult_IN[1:0] != 2'b00) begin
            memwb_d.wb = '0;
            err_d      = 1'b1;
          end else begin
            stall_c = 1'b1;
            addr_d  = AluResult_IN;
            wdata_d = RD2_IN;
            we_d    = MEM_IN[MW_BIT];
            cnt_d   = '0;
            state_d = ACCESS;
            memwb_d = '0;
          end
        end
      end
      ACCESS: begin
        stall_c       = ~DMemReady & ~at_last;
        memwb_d.valid = 1'b1;
        if (DMemReady) begin
          memwb_d.rdata = we_q ? '0 : DMemRData;
          state_d       = IDLE;
        end else if (at_last) begin
          memwb_d.wb = '0;
          err_d      = 1'b1;
          state_d    = IDLE;
        end else begin
          // MEM/WB keeps the bubble captured at issue while waiting.
          cnt_d  = cnt_q + 1'b1;
          load_c = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  memwb_reg u_memwb (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .load_i (load_c),
    .d_i    (memwb_d),
    .q_o    (memwb_q)
  );

  // Stall is partly combinational from EX/MEM, so it is masked during reset.
  assign Stall         = stall_c & Reset_n;
  assign PCSrc         = Valid_IN & MEM_IN[BR_BIT] & Zero_IN;
  assign BranchPC_OUT  = BranchPC_IN;
  assign DMemReq       = (state_q == ACCESS);
  assign DMemWe        = we_q;
  assign DMemAddr      = addr_q;
  assign DMemWData     = wdata_q;
  assign WB_OUT        = memwb_q.wb;
  assign ReadData_OUT  = memwb_q.rdata;
  assign AluResult_OUT = memwb_q.alu;
  assign WR_OUT        = memwb_q.wr;
  assign Valid_OUT     = memwb_q.valid;
  assign MemErr        = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl (TIMEOUT = 16).
module tb_mem_stage_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Valid_IN;
  logic [1:0]  WB_IN;
  logic [2:0]  MEM_IN;
  logic [31:0] BranchPC_IN;
  logic        Zero_IN;
  logic [31:0] AluResult_IN;
  logic [31:0] RD2_IN;
  logic [4:0]  WR_IN;
  logic        Stall, PCSrc;
  logic [31:0] BranchPC_OUT;
  logic        DMemReq, DMemWe;
  logic [31:0] DMemAddr, DMemWData, DMemRData;
  logic        DMemReady;
  logic [1:0]  WB_OUT;
  logic [31:0] ReadData_OUT, AluResult_OUT;
  logic [4:0]  WR_OUT;
  logic        Valid_OUT, MemErr;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;
  int unsigned nstall;

  mem_stage_ctrl #(.TIMEOUT(16), .CNT_W(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Valid_IN(Valid_IN), .WB_IN(WB_IN),
    .MEM_IN(MEM_IN), .BranchPC_IN(BranchPC_IN), .Zero_IN(Zero_IN),
    .AluResult_IN(AluResult_IN), .RD2_IN(RD2_IN), .WR_IN(WR_IN),
    .Stall(Stall), .PCSrc(PCSrc), .BranchPC_OUT(BranchPC_OUT),
    .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr),
    .DMemWData(DMemWData), .DMemRData(DMemRData), .DMemReady(DMemReady),
    .WB_OUT(WB_OUT), .ReadData_OUT(ReadData_OUT), .AluResult_OUT(AluResult_OUT),
    .WR_OUT(WR_OUT), .Valid_OUT(Valid_OUT), .MemErr(MemErr)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [1:0] wb, input logic [2:0] mem,
                        input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] wr);
    Valid_IN = v; WB_IN = wb; MEM_IN = mem; AluResult_IN = alu; RD2_IN = rd2; WR_IN = wr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n = 1'b1; Zero_IN = 1'b0; BranchPC_IN = '0; DMemRData = '0; DMemReady = 1'b0;
    set_in(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
    #2 Reset_n = 1'b0;
    #1;
    check("rst_valid", {31'b0, Valid_OUT}, 32'h0);
    check("rst_memerr", {31'b0, MemErr}, 32'h0);
    check("rst_req", {31'b0, DMemReq}, 32'h0);
    tick();
    Reset_n = 1'b1;
    tick();

    // R-type passthrough
    set_in(1'b1, 2'b10, 3'b000, 32'h1234, 32'h0, 5'd5);
    #1 check("rtype_stall", {31'b0, Stall}, 32'h0);
    tick();
    check("rtype_wb", {30'b0, WB_OUT}, 32'h2);
    check("rtype_alu", AluResult_OUT, 32'h1234);
    check("rtype_wr", {27'b0, WR_OUT}, 32'd5);
    check("rtype_rdata", ReadData_OUT, 32'h0);
    check("rtype_valid", {31'b0, Valid_OUT}, 32'h1);

    // Branch resolve
    set_in(1'b1, 2'b00, 3'b100, 32'h0, 32'h0, 5'd0);
    Zero_IN = 1'b1; BranchPC_IN = 32'h200;
    #1;
    check("br_pcsrc1", {31'b0, PCSrc}, 32'h1);
    check("br_pc", BranchPC_OUT, 32'h200);
    check("br_stall", {31'b0, Stall}, 32'h0);
    Zero_IN = 1'b0;
    #1 check("br_pcsrc0", {31'b0, PCSrc}, 32'h0);
    Zero_IN = 1'b1; Valid_IN = 1'b0;
    #1 check("br_invalid", {31'b0, PCSrc}, 32'h0);
    Zero_IN = 1'b0;

    // DMemReady while idle is ignored
    DMemReady = 1'b1; DMemRData = 32'h5555_5555;
    tick();
    DMemReady = 1'b0;
    check("idle_rdy_req", {31'b0, DMemReq}, 32'h0);
    check("idle_rdy_rdata", ReadData_OUT, 32'h0);

    // Load, memory ready on the 3rd ACCESS cycle
    set_in(1'b1, 2'b11, 3'b010, 32'h100, 32'h0, 5'd7);
    #1 check("ld_issue_stall", {31'b0, Stall}, 32'h1);
    tick();
    check("ld_req", {31'b0, DMemReq}, 32'h1);
    check("ld_addr", DMemAddr, 32'h100);
    check("ld_we", {31'b0, DMemWe}, 32'h0);
    check("ld_bubble", {31'b0, Valid_OUT}, 32'h0);
    check("ld_stall1", {31'b0, Stall}, 32'h1);
    tick();
    check("ld_stall2", {31'b0, Stall}, 32'h1);
    tick();
    DMemReady = 1'b1; DMemRData = 32'hDEADBEEF;
    #1 check("ld_stall_done", {31'b0, Stall}, 32'h0);
    tick();
    DMemReady = 1'b0;
    set_in(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
    check("ld_rdata", ReadData_OUT, 32'hDEADBEEF);
    check("ld_valid", {31'b0, Valid_OUT}, 32'h1);
    check("ld_wb", {30'b0, WB_OUT}, 32'h3);
    check("ld_req_off", {31'b0, DMemReq}, 32'h0);

    // Store, memory ready on the first ACCESS cycle
    set_in(1'b1, 2'b00, 3'b001, 32'h8, 32'hA5A5A5A5, 5'd0);
    #1 check("st_issue_stall", {31'b0, Stall}, 32'h1);
    tick();
    DMemReady = 1'b1; DMemRData = 32'h1234_5678;
    #1;
    check("st_stall", {31'b0, Stall}, 32'h0);
    check("st_we", {31'b0, DMemWe}, 32'h1);
    check("st_wdata", DMemWData, 32'hA5A5A5A5);
    check("st_req", {31'b0, DMemReq}, 32'h1);
    tick();
    DMemReady = 1'b0;
    set_in(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
    check("st_rdata", ReadData_OUT, 32'h0);
    check("st_valid", {31'b0, Valid_OUT}, 32'h1);
    check("st_memerr", {31'b0, MemErr}, 32'h0);

    // Timeout: DMemReady never arrives
    set_in(1'b1, 2'b11, 3'b010, 32'h20, 32'h0, 5'd3);
    nstall = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!Stall) break;
      nstall++;
      @(posedge Clk);
      #1;
    end
    check("to_stall_cycles", nstall, 32'd16);
    check("to_req_last", {31'b0, DMemReq}, 32'h1);
    tick();
    set_in(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
    check("to_memerr", {31'b0, MemErr}, 32'h1);
    check("to_wb", {30'b0, WB_OUT}, 32'h0);
    check("to_rdata", ReadData_OUT, 32'h0);
    check("to_req_off", {31'b0, DMemReq}, 32'h0);

    // Reset mid-ACCESS
    set_in(1'b1, 2'b11, 3'b010, 32'h40, 32'h0, 5'd9);
    tick();
    tick();
    tick();
    check("rm_req_before", {31'b0, DMemReq}, 32'h1);
    Reset_n = 1'b0;
    #1;
    check("rm_req", {31'b0, DMemReq}, 32'h0);
    check("rm_stall", {31'b0, Stall}, 32'h0);
    check("rm_memerr", {31'b0, MemErr}, 32'h0);
    check("rm_alu", AluResult_OUT, 32'h0);
    check("rm_wr", {27'b0, WR_OUT}, 32'h0);
    DMemReady = 1'b1; DMemRData = 32'hCAFE_F00D;
    tick();
    set_in(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
    Reset_n = 1'b1;
    tick();
    DMemReady = 1'b0;
    check("rm_late_rdata", ReadData_OUT, 32'h0);
    check("rm_late_valid", {31'b0, Valid_OUT}, 32'h0);
    check("rm_late_req", {31'b0, DMemReq}, 32'h0);

    // Misaligned load
    set_in(1'b1, 2'b11, 3'b010, 32'h102, 32'h0, 5'd4);
    #1;
    check("mis_stall", {31'b0, Stall}, 32'h0);
    check("mis_req0", {31'b0, DMemReq}, 32'h0);
    tick();
    set_in(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
    check("mis_req1", {31'b0, DMemReq}, 32'h0);
    check("mis_memerr", {31'b0, MemErr}, 32'h1);
    check("mis_wb", {30'b0, WB_OUT}, 32'h0);
    check("mis_rdata", ReadData_OUT, 32'h0);
    tick();
    check("mis_req2", {31'b0, DMemReq}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage consumer of the EX/MEM pipeline register. It receives the WB/MEM control, BranchPC, Zero, ALU result, RD2 and WR, and resolves the branch decision (PCSrc).
- It runs loads and stores against a variable-latency data-memory port using a req/ready handshake. While an access is outstanding it stalls the upstream stages.
- It writes the MEM/WB pipeline register that feeds writeback.

Parameters:
- TIMEOUT, 16: maximum cycles spent in ACCESS waiting for DMemReady before the access is forced to complete; legal range 2..255.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- Clk  in  1  single clock; all state updates on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Valid_IN  in  1  EX/MEM holds a valid instruction.
- WB_IN  in  2  [1]=RegWrite, [0]=MemtoReg.
- MEM_IN  in  3  [2]=Branch, [1]=MemRead, [0]=MemWrite.
- BranchPC_IN  in  32  branch target.
- Zero_IN  in  1  ALU zero flag.
- AluResult_IN  in  32  ALU result / memory byte address.
- RD2_IN  in  32  store data.
- WR_IN  in  5  destination register.
- Stall  out  1  upstream holds IF/ID, ID/EX and EX/MEM when high.
- PCSrc  out  1  Valid_IN & Branch & Zero_IN (combinational).
- BranchPC_OUT  out  32  BranchPC_IN passthrough.
- DMemReq  out  1  memory request.
- DMemWe  out  1  1 = write, 0 = read; meaningful only while DMemReq is high.
- DMemAddr  out  32  latched word address.
- DMemWData  out  32  latched store data.
- DMemRData  in  32  read data; valid when DMemReady is high.
- DMemReady  in  1  access complete this cycle.
- WB_OUT  out  2  MEM/WB control.
- ReadData_OUT  out  32  MEM/WB load data.
- AluResult_OUT  out  32  MEM/WB ALU result.
- WR_OUT  out  5  MEM/WB destination register.
- Valid_OUT  out  1  MEM/WB holds a valid instruction.
- MemErr  out  1  sticky error flag.

Behaviour:
- Reset: all MEM/WB outputs = 0, Valid_OUT = 0, MemErr = 0, FSM = IDLE, counter = 0, DMemReq = 0. Reset is asynchronous and takes effect immediately, including mid-access; any memory response arriving after reset is ignored.
- memop = Valid_IN & (MemRead | MemWrite). MemRead and MemWrite both set: treat as a write, set MemErr.
- FSM states: IDLE, ACCESS.
- IDLE, no memop:
  - Stall = 0.
  - MEM/WB captures at the next edge: {WB_IN, ReadData = 0, AluResult_IN, WR_IN, Valid_IN}.
  - Zero-latency passthrough.
- IDLE, memop with misaligned address (AluResult_IN[1:0] != 0):
  - No request is issued. Stall = 0.
  - MEM/WB captures with ReadData = 0 and WB_OUT forced to 0, so there is no writeback.
  - MemErr is set.
- IDLE, memop, aligned address:
  - Stall = 1.
  - Latch DMemAddr = AluResult_IN, DMemWData = RD2_IN, DMemWe = MemWrite.
  - Go to ACCESS. Counter = 0.
  - MEM/WB captures a bubble (Valid_OUT = 0, WB_OUT = 0).
- ACCESS:
  - DMemReq = 1. Address, write data and DMemWe stay stable until completion.
  - Stall = ~DMemReady & (counter != TIMEOUT-1).
  - If DMemReady: MEM/WB captures {WB_IN, DMemRData (0 for stores), AluResult_IN, WR_IN, 1}; go to IDLE.
  - Else if counter == TIMEOUT-1: forced completion. Capture with ReadData = 0 and WB_OUT = 0, set MemErr, go to IDLE.
  - Else counter increments.
- Latency: a load/store costs at least 2 cycles, i.e. one stall cycle when DMemReady arrives on the first ACCESS cycle. Worst case is TIMEOUT+1 cycles.
- Stall drops in the completing cycle, so upstream advances at the same edge MEM/WB captures. No instruction is issued twice and no bubble is added.
- Back-to-back memops: the second memop is seen in IDLE on the cycle after completion and issues normally.
- DMemReady outside ACCESS is ignored.
- PCSrc and BranchPC_OUT are combinational and independent of the FSM. Branch instructions carry no memop and never stall.
- MemErr clears only on reset.

Decomposition:
- Shared package mips_pkg holds:
  - bit-index constants for WB (RW_BIT = 1, M2R_BIT = 0);
  - bit-index constants for MEM (BR_BIT = 2, MR_BIT = 1, MW_BIT = 0);
  - FSM state encoding (IDLE = 0, ACCESS = 1).
- One natural sub-module, memwb_reg: the MEM/WB register with async active-low reset and load-enable. The FSM and handshake stay in mem_stage_ctrl.

Test Plan:
- Reset mid-ACCESS:
  - Stimulus: load to 0x40, DMemReady held low, pull Reset_n low after 3 cycles.
  - Response: DMemReq = 0 immediately, Stall = 0, all outputs 0, MemErr = 0. A late DMemReady pulse is ignored.
- R-type passthrough:
  - Stimulus: Valid_IN = 1, WB_IN = 2'b10, MEM_IN = 0, AluResult_IN = 0x1234, WR_IN = 5.
  - Response: Stall never high. Next cycle WB_OUT = 2'b10, AluResult_OUT = 0x1234, WR_OUT = 5, ReadData_OUT = 0, Valid_OUT = 1.
- Load with 3-cycle memory:
  - Stimulus: MEM_IN = 3'b010, AluResult_IN = 0x100, DMemReady high on the 3rd ACCESS cycle with DMemRData = 0xDEADBEEF.
  - Response: Stall high for 3 cycles and low in the completing cycle, DMemAddr = 0x100, DMemWe = 0. Then ReadData_OUT = 0xDEADBEEF, Valid_OUT = 1.
- Store immediate-ready:
  - Stimulus: MEM_IN = 3'b001, AluResult_IN = 0x8, RD2_IN = 0xA5A5A5A5, DMemReady high on the first ACCESS cycle.
  - Response: exactly one stall cycle, DMemWe = 1, DMemWData = 0xA5A5A5A5, ReadData_OUT = 0.
- Timeout and misalignment:
  - Stimulus (a): load with DMemReady stuck low, TIMEOUT = 16. Response: Stall high for exactly 16 cycles, then MemErr = 1, WB_OUT = 0.
  - Stimulus (b): load at address 0x102. Response: DMemReq never asserted, MemErr = 1, no stall.
- Branch:
  - Stimulus: Valid_IN = 1, MEM_IN = 3'b100, Zero_IN = 1, BranchPC_IN = 0x200. Response: PCSrc = 1, BranchPC_OUT = 0x200 in the same cycle.
  - Stimulus: same with Zero_IN = 0. Response: PCSrc = 0.
